// File: rtl/uart_frame_check_stat_if.sv
// Frame-checker bus: sampled frame fields in, checked result and statistics out.
// master = deserialiser/host side, slave = the checker.
interface uart_frame_check_stat_if #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 16
);
  logic                  frame_valid;
  logic [1:0]            parity_type;
  logic                  start_bit;
  logic                  parity_bit;
  logic [STOP_BITS-1:0]  stop_bits;
  logic [DATA_WIDTH-1:0] raw_data;
  logic                  stat_clear;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [2:0]            error_flag;
  logic                  break_det;
  logic [2:0]            sticky_error;
  logic [CNT_WIDTH-1:0]  parity_err_cnt;
  logic [CNT_WIDTH-1:0]  start_err_cnt;
  logic [CNT_WIDTH-1:0]  stop_err_cnt;
  logic [CNT_WIDTH-1:0]  break_cnt;
  logic [CNT_WIDTH-1:0]  frame_cnt;

  modport master (
    output frame_valid, parity_type, start_bit, parity_bit, stop_bits, raw_data, stat_clear,
    input  out_valid, out_data, error_flag, break_det, sticky_error,
           parity_err_cnt, start_err_cnt, stop_err_cnt, break_cnt, frame_cnt
  );

  modport slave (
    input  frame_valid, parity_type, start_bit, parity_bit, stop_bits, raw_data, stat_clear,
    output out_valid, out_data, error_flag, break_det, sticky_error,
           parity_err_cnt, start_err_cnt, stop_err_cnt, break_cnt, frame_cnt
  );
endinterface

// File: rtl/uart_frame_check_stat.sv
// UART receive-frame checker: start/parity/stop checks, BREAK detection,
// saturating per-error statistics and sticky status for the host.
module uart_frame_check_stat #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  uart_frame_check_stat_if.slave bus
);

  typedef enum logic {ST_NORMAL, ST_BREAK} state_t;

  localparam int NUM_CNT = 5;  // parity, start, stop, break, frame

  state_t                state_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [2:0]            error_flag_reg;
  logic                  break_det_reg;
  logic [2:0]            sticky_reg;

  logic                  par_en;
  logic                  par_exp;
  logic                  stop_ok;
  logic                  is_break;
  logic                  emit;
  logic                  emit_break;
  logic [2:0]            flags_next;
  logic [NUM_CNT-1:0]    cnt_inc;

  always_comb begin
    par_en     = (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
    par_exp    = (bus.parity_type == 2'b01) ? ~^bus.raw_data : ^bus.raw_data;
    stop_ok    = &bus.stop_bits;
    is_break   = !bus.start_bit && (bus.raw_data == '0) && (bus.stop_bits == '0);
    emit       = 1'b0;
    emit_break = 1'b0;
    if (bus.frame_valid) begin
      if (state_reg == ST_NORMAL) begin
        emit       = 1'b1;
        emit_break = is_break;
      end else if (stop_ok) begin
        // Line has returned to idle: this frame ends the BREAK and is checked normally.
        emit = 1'b1;
      end
    end
    flags_next = emit_break ? 3'b100
                            : {!stop_ok, bus.start_bit, par_en && (bus.parity_bit != par_exp)};
    cnt_inc    = {NUM_CNT{emit}} &
                 {1'b1, emit_break, flags_next[2] && !emit_break, flags_next[1], flags_next[0]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_NORMAL;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      error_flag_reg <= '0;
      break_det_reg  <= 1'b0;
    end else begin
      out_valid_reg <= emit;
      if (emit) begin
        out_data_reg   <= bus.raw_data;
        error_flag_reg <= flags_next;
        break_det_reg  <= emit_break;
      end
      if (bus.frame_valid) begin
        case (state_reg)
          ST_NORMAL: if (is_break) state_reg <= ST_BREAK;
          ST_BREAK:  if (stop_ok)  state_reg <= ST_NORMAL;
          default:   state_reg <= ST_NORMAL;
        endcase
      end
    end
  end

  // Clear zeroes the base first, so a frame in the same cycle counts from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_reg <= '0;
    end else if (bus.stat_clear) begin
      sticky_reg <= emit ? flags_next : 3'b000;
    end else if (emit) begin
      sticky_reg <= sticky_reg | flags_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] base;

      assign base = bus.stat_clear ? '0 : cnt_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (bus.stat_clear || cnt_inc[gi]) begin
          if (cnt_inc[gi])
            cnt_reg <= (&base) ? base : base + 1'b1;
          else
            cnt_reg <= '0;
        end
      end
    end
  endgenerate

  assign bus.out_valid      = out_valid_reg;
  assign bus.out_data       = out_data_reg;
  assign bus.error_flag     = error_flag_reg;
  assign bus.break_det      = break_det_reg;
  assign bus.sticky_error   = sticky_reg;
  assign bus.parity_err_cnt = g_cnt[0].cnt_reg;
  assign bus.start_err_cnt  = g_cnt[1].cnt_reg;
  assign bus.stop_err_cnt   = g_cnt[2].cnt_reg;
  assign bus.break_cnt      = g_cnt[3].cnt_reg;
  assign bus.frame_cnt      = g_cnt[4].cnt_reg;

endmodule

// File: tb/tb_uart_frame_check_stat.sv
// Directed bench for uart_frame_check_stat: one 8-bit/1-stop/4-bit-counter instance
// for the main function, plus 5-bit and 9-bit instances with two stop bits.
module tb_uart_frame_check_stat;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clock = ~clock;

  uart_frame_check_stat_if #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(4)) bus_a ();
  uart_frame_check_stat_if #(.DATA_WIDTH(5), .STOP_BITS(2), .CNT_WIDTH(8)) bus_b ();
  uart_frame_check_stat_if #(.DATA_WIDTH(9), .STOP_BITS(2), .CNT_WIDTH(8)) bus_c ();

  uart_frame_check_stat #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  uart_frame_check_stat #(.DATA_WIDTH(5), .STOP_BITS(2), .CNT_WIDTH(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));
  uart_frame_check_stat #(.DATA_WIDTH(9), .STOP_BITS(2), .CNT_WIDTH(8)) dut_c (
    .clock(clock), .reset_n(reset_n), .bus(bus_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One frame on instance A; returns 1 ns after the capturing edge.
  task automatic frame_a(input logic [1:0] pt, input logic st, input logic pb, input logic sp,
                         input logic [7:0] d, input logic clr);
    bus_a.frame_valid = 1'b1;
    bus_a.parity_type = pt;
    bus_a.start_bit   = st;
    bus_a.parity_bit  = pb;
    bus_a.stop_bits   = sp;
    bus_a.raw_data    = d;
    bus_a.stat_clear  = clr;
    step();
    bus_a.frame_valid = 1'b0;
    bus_a.stat_clear  = 1'b0;
    $display("frame A: data=%02h start=%0b stop=%0b par=%0b pt=%0d clr=%0b -> valid=%0b flags=%03b brk=%0b",
             d, st, sp, pb, pt, clr, bus_a.out_valid, bus_a.error_flag, bus_a.break_det);
  endtask

  task automatic frame_b(input logic [1:0] pt, input logic st, input logic pb, input logic [1:0] sp,
                         input logic [4:0] d);
    bus_b.frame_valid = 1'b1;
    bus_b.parity_type = pt;
    bus_b.start_bit   = st;
    bus_b.parity_bit  = pb;
    bus_b.stop_bits   = sp;
    bus_b.raw_data    = d;
    step();
    bus_b.frame_valid = 1'b0;
    $display("frame B: data=%02h stop=%02b -> valid=%0b flags=%03b brk=%0b",
             d, sp, bus_b.out_valid, bus_b.error_flag, bus_b.break_det);
  endtask

  task automatic frame_c(input logic [1:0] pt, input logic st, input logic pb, input logic [1:0] sp,
                         input logic [8:0] d);
    bus_c.frame_valid = 1'b1;
    bus_c.parity_type = pt;
    bus_c.start_bit   = st;
    bus_c.parity_bit  = pb;
    bus_c.stop_bits   = sp;
    bus_c.raw_data    = d;
    step();
    bus_c.frame_valid = 1'b0;
    $display("frame C: data=%03h stop=%02b par=%0b -> valid=%0b flags=%03b",
             d, sp, pb, bus_c.out_valid, bus_c.error_flag);
  endtask

  initial begin
    bus_a.frame_valid = 0; bus_a.parity_type = 0; bus_a.start_bit = 0; bus_a.parity_bit = 0;
    bus_a.stop_bits = 0; bus_a.raw_data = 0; bus_a.stat_clear = 0;
    bus_b.frame_valid = 0; bus_b.parity_type = 0; bus_b.start_bit = 0; bus_b.parity_bit = 0;
    bus_b.stop_bits = 0; bus_b.raw_data = 0; bus_b.stat_clear = 0;
    bus_c.frame_valid = 0; bus_c.parity_type = 0; bus_c.start_bit = 0; bus_c.parity_bit = 0;
    bus_c.stop_bits = 0; bus_c.raw_data = 0; bus_c.stat_clear = 0;

    // Reset state
    step(); step();
    chk("rst_out_valid", 32'(bus_a.out_valid), 0);
    chk("rst_frame_cnt", 32'(bus_a.frame_cnt), 0);
    chk("rst_sticky", 32'(bus_a.sticky_error), 0);
    chk("rst_out_data", 32'(bus_a.out_data), 0);
    #3 reset_n = 1'b1;
    step();

    // Clean frame, even parity, A5 has four ones
    frame_a(2'b10, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    chk("clean_valid", 32'(bus_a.out_valid), 1);
    chk("clean_flags", 32'(bus_a.error_flag), 0);
    chk("clean_data", 32'(bus_a.out_data), 32'hA5);
    chk("clean_frame_cnt", 32'(bus_a.frame_cnt), 1);
    step();
    chk("clean_valid_drop", 32'(bus_a.out_valid), 0);
    chk("clean_data_hold", 32'(bus_a.out_data), 32'hA5);

    // Mixed errors: odd parity on 01 expects 0, bit is 1
    frame_a(2'b01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
    chk("mixed_flags", 32'(bus_a.error_flag), 32'b111);
    chk("mixed_par_cnt", 32'(bus_a.parity_err_cnt), 1);
    chk("mixed_start_cnt", 32'(bus_a.start_err_cnt), 1);
    chk("mixed_stop_cnt", 32'(bus_a.stop_err_cnt), 1);
    chk("mixed_sticky", 32'(bus_a.sticky_error), 32'b111);
    chk("mixed_frame_cnt", 32'(bus_a.frame_cnt), 2);

    // Clear without a frame
    bus_a.stat_clear = 1'b1;
    step();
    bus_a.stat_clear = 1'b0;
    chk("clr_frame_cnt", 32'(bus_a.frame_cnt), 0);
    chk("clr_sticky", 32'(bus_a.sticky_error), 0);
    chk("clr_flags_held", 32'(bus_a.error_flag), 32'b111);

    // BREAK entry
    frame_a(2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("brk_valid", 32'(bus_a.out_valid), 1);
    chk("brk_det", 32'(bus_a.break_det), 1);
    chk("brk_flags", 32'(bus_a.error_flag), 32'b100);
    chk("brk_cnt", 32'(bus_a.break_cnt), 1);
    chk("brk_stop_cnt", 32'(bus_a.stop_err_cnt), 0);
    chk("brk_sticky", 32'(bus_a.sticky_error), 32'b100);

    // Absorbed frames while in BREAK
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      frame_a(2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      if (bus_a.out_valid) pulses++;
    end
    frame_a(2'b10, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
    if (bus_a.out_valid) pulses++;
    chk("brk_absorb_pulses", 32'(pulses), 0);
    chk("brk_absorb_frame_cnt", 32'(bus_a.frame_cnt), 1);
    chk("brk_absorb_brk_cnt", 32'(bus_a.break_cnt), 1);

    // Exit BREAK with a good stop bit
    frame_a(2'b00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("exit_valid", 32'(bus_a.out_valid), 1);
    chk("exit_brk_det", 32'(bus_a.break_det), 0);
    chk("exit_flags", 32'(bus_a.error_flag), 0);
    chk("exit_frame_cnt", 32'(bus_a.frame_cnt), 2);
    // Back in NORMAL a bad stop bit is reported, not absorbed
    frame_a(2'b00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0);
    chk("normal_stop_valid", 32'(bus_a.out_valid), 1);
    chk("normal_stop_flags", 32'(bus_a.error_flag), 32'b100);
    chk("normal_stop_cnt", 32'(bus_a.stop_err_cnt), 1);
    chk("normal_brk_cnt", 32'(bus_a.break_cnt), 1);

    // 20 back-to-back parity errors: even parity on 01 expects 1, bit is 0
    pulses = 0;
    bus_a.frame_valid = 1'b1;
    bus_a.parity_type = 2'b10; bus_a.start_bit = 1'b0; bus_a.parity_bit = 1'b0;
    bus_a.stop_bits = 1'b1; bus_a.raw_data = 8'h01;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_a.out_valid) pulses++;
    end
    bus_a.frame_valid = 1'b0;
    $display("burst A: 20 parity-error frames -> pulses=%0d par_cnt=%0d frame_cnt=%0d",
             pulses, bus_a.parity_err_cnt, bus_a.frame_cnt);
    chk("sat_pulses", 32'(pulses), 20);
    chk("sat_par_cnt", 32'(bus_a.parity_err_cnt), 15);
    chk("sat_frame_cnt", 32'(bus_a.frame_cnt), 15);
    chk("sat_sticky", 32'(bus_a.sticky_error), 32'b101);

    // Clear together with a parity-error frame
    frame_a(2'b10, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
    chk("clrfr_par_cnt", 32'(bus_a.parity_err_cnt), 1);
    chk("clrfr_frame_cnt", 32'(bus_a.frame_cnt), 1);
    chk("clrfr_stop_cnt", 32'(bus_a.stop_err_cnt), 0);
    chk("clrfr_sticky", 32'(bus_a.sticky_error), 32'b001);

    // Asynchronous reset mid-stream discards a pending frame
    frame_a(2'b00, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0);
    chk("pre_rst_valid", 32'(bus_a.out_valid), 1);
    bus_a.frame_valid = 1'b1;
    bus_a.raw_data = 8'h3C;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus_a.out_valid), 0);
    chk("async_rst_data", 32'(bus_a.out_data), 0);
    chk("async_rst_frame_cnt", 32'(bus_a.frame_cnt), 0);
    step();
    chk("rst_hold_valid", 32'(bus_a.out_valid), 0);
    bus_a.frame_valid = 1'b0;
    #2 reset_n = 1'b1;
    step();
    frame_a(2'b00, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0);
    chk("post_rst_valid", 32'(bus_a.out_valid), 1);
    chk("post_rst_data", 32'(bus_a.out_data), 32'h96);
    chk("post_rst_frame_cnt", 32'(bus_a.frame_cnt), 1);

    // 5-bit data, two stop bits
    frame_b(2'b00, 1'b0, 1'b0, 2'b10, 5'h15);
    chk("b_stop_flags", 32'(bus_b.error_flag), 32'b100);
    chk("b_stop_cnt", 32'(bus_b.stop_err_cnt), 1);
    chk("b_stop_brk", 32'(bus_b.break_det), 0);
    frame_b(2'b00, 1'b0, 1'b0, 2'b11, 5'h0A);
    chk("b_clean_flags", 32'(bus_b.error_flag), 0);
    chk("b_clean_data", 32'(bus_b.out_data), 32'h0A);
    frame_b(2'b00, 1'b0, 1'b0, 2'b00, 5'h00);
    chk("b_brk_det", 32'(bus_b.break_det), 1);
    chk("b_brk_cnt", 32'(bus_b.break_cnt), 1);
    chk("b_frame_cnt", 32'(bus_b.frame_cnt), 3);

    // 9-bit data, odd parity: 1FF has nine ones so expected parity bit is 0
    frame_c(2'b01, 1'b0, 1'b0, 2'b11, 9'h1FF);
    chk("c_ok_flags", 32'(bus_c.error_flag), 0);
    chk("c_ok_data", 32'(bus_c.out_data), 32'h1FF);
    frame_c(2'b01, 1'b0, 1'b1, 2'b11, 9'h1FF);
    chk("c_par_flags", 32'(bus_c.error_flag), 32'b001);
    frame_c(2'b11, 1'b0, 1'b1, 2'b01, 9'h100);
    chk("c_stop_flags", 32'(bus_c.error_flag), 32'b100);
    chk("c_par_cnt", 32'(bus_c.parity_err_cnt), 1);
    chk("c_stop_cnt", 32'(bus_c.stop_err_cnt), 1);

    // 8 back-to-back frames on instance C
    pulses = 0;
    bus_c.frame_valid = 1'b1;
    bus_c.parity_type = 2'b00; bus_c.stop_bits = 2'b11; bus_c.start_bit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_c.raw_data = 9'(i + 1);
      step();
      if (bus_c.out_valid && bus_c.out_data == 9'(i + 1)) pulses++;
    end
    bus_c.frame_valid = 1'b0;
    $display("burst C: 8 frames -> matching pulses=%0d frame_cnt=%0d", pulses, bus_c.frame_cnt);
    chk("c_b2b_pulses", 32'(pulses), 8);
    chk("c_b2b_frame_cnt", 32'(bus_c.frame_cnt), 11);
    step();
    chk("c_b2b_idle", 32'(bus_c.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
